// File: rtl/noc_adder.sv
// Compute tile at mesh position (0,1): pairs up incoming operand beats in arrival
// order, adds them and forwards one single-beat result packet to tile (1,1).
module noc_adder #(
   parameter int               TDATAW   = 32,
   parameter int               TDESTW   = 4,
   parameter int               TIDW     = 2,
   parameter logic [TDESTW-1:0] DEST_OUT = 4'd3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              AXIS_S_TVALID,
   output logic              AXIS_S_TREADY,
   input  logic [TDATAW-1:0] AXIS_S_TDATA,
   input  logic              AXIS_S_TLAST,
   input  logic [TDESTW-1:0] AXIS_S_TDEST,
   output logic              AXIS_M_TVALID,
   input  logic              AXIS_M_TREADY,
   output logic [TDATAW-1:0] AXIS_M_TDATA,
   output logic              AXIS_M_TLAST,
   output logic [TDESTW-1:0] AXIS_M_TDEST
);

   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      SEND   = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [TDATAW-1:0] op_a;
   logic [TDATAW-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tlast;
   logic              s_tready;
   logic              in_fire;
   logic              out_fire;

   // Packet framing and own address on the input side carry no information here.
   localparam int unused_tidw = TIDW;
   logic unused_inputs;
   assign unused_inputs = ^{AXIS_S_TLAST, AXIS_S_TDEST};

   assign in_fire  = AXIS_S_TVALID && s_tready;
   assign out_fire = m_tvalid && AXIS_M_TREADY;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         WAIT_A:  if (in_fire)  state_d = WAIT_B;
         WAIT_B:  if (in_fire)  state_d = SEND;
         SEND:    if (out_fire) state_d = WAIT_A;
         default: state_d = WAIT_A;
      endcase
   end

   // Ready is registered from the next state so no input reaches an output
   // combinationally; it stays low for the cycle following reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= WAIT_A;
         op_a     <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         s_tready <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_tready <= (state_d != SEND);
         if (in_fire && state_q == WAIT_A)
            op_a <= AXIS_S_TDATA;
         if (in_fire && state_q == WAIT_B) begin
            m_tdata  <= op_a + AXIS_S_TDATA;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b1;
         end else if (out_fire) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
         end
      end
   end

   assign AXIS_S_TREADY = s_tready;
   assign AXIS_M_TVALID = m_tvalid;
   assign AXIS_M_TDATA  = m_tdata;
   assign AXIS_M_TLAST  = m_tlast;
   assign AXIS_M_TDEST  = DEST_OUT;

endmodule

// File: tb/tb_noc_adder.sv
// Bench for noc_adder: directed vector table, corner sequences, and randomized
// traffic checked by a pairing scoreboard that observes both stream interfaces.
module tb_noc_adder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        s_last;
   logic [3:0]  s_dest;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;
   logic [3:0]  m_dest;

   int checks = 0;
   int errors = 0;

   noc_adder dut (
      .CLK           (CLK),
      .RST           (RST),
      .AXIS_S_TVALID (s_valid),
      .AXIS_S_TREADY (s_ready),
      .AXIS_S_TDATA  (s_data),
      .AXIS_S_TLAST  (s_last),
      .AXIS_S_TDEST  (s_dest),
      .AXIS_M_TVALID (m_valid),
      .AXIS_M_TREADY (m_ready),
      .AXIS_M_TDATA  (m_data),
      .AXIS_M_TLAST  (m_last),
      .AXIS_M_TDEST  (m_dest)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one operand and hold it until accepted; returns just after the accepting edge.
   task automatic applyStimulus(input logic [31:0] d);
      bit done = 0;
      s_valid = 1'b1;
      s_data  = d;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge CLK);
         if (s_ready) done = 1;
         @(posedge CLK);
         #1;
      end
      s_valid = 1'b0;
      if (!done) checkOutput("s_tready_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitResult(input string name, input logic [31:0] exp);
      bit done = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge CLK);
         if (m_valid) begin
            done = 1;
            checkOutput(name, m_data, exp);
         end
         @(posedge CLK);
         #1;
      end
      if (!done) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   // Reference: operands pair up strictly in acceptance order; reset drops any half pair
   // and any result not yet delivered.
   logic [31:0] pend;
   bit          have_pend = 0;
   logic [31:0] expq[$];

   always @(negedge CLK) begin
      if (RST) begin
         have_pend = 0;
         expq.delete();
      end else begin
         if (s_valid && s_ready) begin
            if (have_pend) begin
               expq.push_back(pend + s_data);
               have_pend = 0;
            end else begin
               pend      = s_data;
               have_pend = 1;
            end
         end
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               checkOutput("sb_unexpected_result", m_data, 32'hxxxx_xxxx);
            end else begin
               checkOutput("sb_data", m_data, expq.pop_front());
               checkOutput("sb_tlast", {31'd0, m_last}, 32'd1);
               checkOutput("sb_tdest", {28'd0, m_dest}, 32'd3);
            end
         end
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sum;
   } vec_t;

   vec_t vecs[5];
   logic [7:0] la, lb;
   bit hs;

   initial begin
      vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
      vecs[1] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
      vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
      vecs[4] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789};

      RST = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b1; s_dest = 4'd1; m_ready = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checkOutput("rst_m_tvalid", {31'd0, m_valid}, 32'd0);
      checkOutput("rst_m_tdata", m_data, 32'd0);
      checkOutput("rst_m_tlast", {31'd0, m_last}, 32'd0);
      checkOutput("rst_m_tdest", {28'd0, m_dest}, 32'd3);
      checkOutput("rst_s_tready", {31'd0, s_ready}, 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;

      // Table: back-to-back A/B with sink always ready, including wrap cases.
      m_ready = 1'b1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].a);
         applyStimulus(vecs[i].b);
         @(negedge CLK);
         checkOutput("vec_m_tvalid", {31'd0, m_valid}, 32'd1);
         checkOutput("vec_sum", m_data, vecs[i].sum);
         checkOutput("vec_tlast", {31'd0, m_last}, 32'd1);
         checkOutput("vec_tdest", {28'd0, m_dest}, 32'd3);
         checkOutput("vec_s_tready_send", {31'd0, s_ready}, 32'd0);
         @(posedge CLK); #1;
         @(negedge CLK);
         checkOutput("vec_m_tvalid_clr", {31'd0, m_valid}, 32'd0);
         checkOutput("vec_tlast_clr", {31'd0, m_last}, 32'd0);
         checkOutput("vec_s_tready_back", {31'd0, s_ready}, 32'd1);
         @(posedge CLK); #1;
      end

      // Output backpressure: result held stable for ten cycles, input stalled.
      m_ready = 1'b0;
      applyStimulus(32'h2);
      applyStimulus(32'h3);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         checkOutput("bp_m_tvalid", {31'd0, m_valid}, 32'd1);
         checkOutput("bp_m_tdata", m_data, 32'h5);
         checkOutput("bp_m_tlast", {31'd0, m_last}, 32'd1);
         checkOutput("bp_s_tready", {31'd0, s_ready}, 32'd0);
         @(posedge CLK); #1;
      end
      m_ready = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      checkOutput("bp_done_m_tvalid", {31'd0, m_valid}, 32'd0);
      @(posedge CLK); #1;

      // Reset between A and B discards the half pair.
      applyStimulus(32'h55);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("mrst_m_tvalid", {31'd0, m_valid}, 32'd0);
      checkOutput("mrst_s_tready", {31'd0, s_ready}, 32'd0);
      @(posedge CLK); #1;
      applyStimulus(32'h1);
      @(negedge CLK);
      checkOutput("mrst_no_output", {31'd0, m_valid}, 32'd0);
      @(posedge CLK); #1;
      applyStimulus(32'h2);
      waitResult("mrst_sum", 32'h3);

      // Five LFSR-generated pairs.
      la = 8'h01;
      lb = 8'h10;
      for (int i = 0; i < 5; i++) begin
         applyStimulus({24'd0, la});
         applyStimulus({24'd0, lb});
         waitResult("lfsr_sum", {24'd0, la} + {24'd0, lb});
         la = lfsr_next(la);
         lb = lfsr_next(lb);
      end

      // Random traffic on both sides, checked by the scoreboard only.
      s_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge CLK);
         hs = s_valid && s_ready;
         @(posedge CLK); #1;
         if (!s_valid || hs) begin
            s_valid = $urandom_range(0, 1) == 1;
            s_data  = $urandom;
         end
         m_ready = $urandom_range(0, 2) != 0;
      end
      @(negedge CLK);
      hs = s_valid && s_ready;
      @(posedge CLK); #1;
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (10) @(posedge CLK);
      @(negedge CLK);
      checkOutput("sb_drained", expq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
